// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter with parametrised frame format and TX FIFO;
//            frames leave back-to-back. Optional line break: UART_TX_BREAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef UART_TX_BREAK_EN
    input  logic                          tx_break,
`endif
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);
    localparam int c_AW           = $clog2(FIFO_DEPTH);
    localparam int c_CW           = c_AW + 1;
    localparam int c_IDX_W        = 4;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_DATA = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);
    localparam logic [c_CW-1:0]    c_FULL      = c_CW'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic                 w_break;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = tx_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_par = (PARITY == 1) ? ~(^w_head) : (^w_head);

`ifdef UART_TX_BREAK_EN
    assign w_break = tx_break;
`else
    assign w_break = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ----------------------------------------------------------------- FSM
    logic [2:0]           r_state,   w_state_nxt;
    logic [c_CNT_W-1:0]   r_clk_cnt, w_clk_cnt_nxt;
    logic [c_IDX_W-1:0]   r_bit_idx, w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                 r_par_bit, w_par_bit_nxt;
    logic                 r_serial,  w_serial_nxt;
    logic                 r_recover, w_recover_nxt;
    logic                 w_bit_end;

    assign w_bit_end = (r_clk_cnt == c_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_serial  <= 1'b1;
            r_recover <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_serial  <= w_serial_nxt;
            r_recover <= w_recover_nxt;
        end
    end

    // The line value is computed alongside each transition so it changes on
    // the same edge the new state or bit begins.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_par_bit_nxt = r_par_bit;
        w_serial_nxt  = r_serial;
        w_recover_nxt = r_recover;
        w_pop         = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_serial_nxt = 1'b1;
                if (w_break) begin
                    w_serial_nxt  = 1'b0;
                    w_recover_nxt = 1'b1;
                    w_clk_cnt_nxt = '0;
                end else if (r_recover) begin
                    // One full high bit period after a break before any frame
                    if (w_bit_end) begin
                        w_recover_nxt = 1'b0;
                        w_clk_cnt_nxt = '0;
                    end else begin
                        w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                    end
                end else if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
                    w_par_bit_nxt = w_head_par;
                    w_bit_idx_nxt = '0;
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = c_START;
                    w_serial_nxt  = 1'b0;
                end
            end

            c_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = c_DATA;
                    w_serial_nxt  = r_shift[0];
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end

            c_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == c_LAST_DATA) begin
                        w_bit_idx_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt  = c_PAR;
                            w_serial_nxt = r_par_bit;
                        end else begin
                            w_state_nxt  = c_STOP;
                            w_serial_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + c_IDX_W'(1);
                        w_shift_nxt   = r_shift >> 1;
                        w_serial_nxt  = r_shift[1];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end

            c_PAR: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = c_STOP;
                    w_serial_nxt  = 1'b1;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end

            c_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == c_LAST_STOP) begin
                        w_bit_idx_nxt = '0;
                        if (!w_empty && !w_break) begin
                            w_pop         = 1'b1;
                            w_shift_nxt   = w_head;
                            w_par_bit_nxt = w_head_par;
                            w_state_nxt   = c_START;
                            w_serial_nxt  = 1'b0;
                        end else begin
                            w_state_nxt   = c_IDLE;
                            w_serial_nxt  = !w_break;
                            w_recover_nxt = w_break;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + c_IDX_W'(1);
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt  = c_IDLE;
                w_serial_nxt = 1'b1;
            end
        endcase
    end

    assign tx_ready   = !w_full;
    assign tx_serial  = r_serial;
    assign tx_busy    = (r_state != c_IDLE);
    assign fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo (8N1, 7E2, 7O2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_break = 1'b0;

    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0;
    logic       m_ready, m_serial, m_busy;
    logic [2:0] m_count;

    logic [6:0] e_data = '0;
    logic       e_valid = 1'b0;
    logic       e_ready, e_serial, e_busy;
    logic [2:0] e_count;

    logic [6:0] o_data = '0;
    logic       o_valid = 1'b0;
    logic       o_ready, o_serial, o_busy;
    logic [2:0] o_count;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_tally = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
        .tx_break(tx_break),
`endif
        .tx_data(m_data), .tx_valid(m_valid), .tx_ready(m_ready),
        .tx_serial(m_serial), .tx_busy(m_busy), .fifo_count(m_count));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_data(e_data), .tx_valid(e_valid), .tx_ready(e_ready),
        .tx_serial(e_serial), .tx_busy(e_busy), .fifo_count(e_count));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                   .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx_data(o_data), .tx_valid(o_valid), .tx_ready(o_ready),
        .tx_serial(o_serial), .tx_busy(o_busy), .fifo_count(o_count));

    // Line receiver on the 8N1 instance: samples mid-bit, logs data and start cycle
    int         cyc = 0;
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_t0 = 0;
    int         rx_bad = 0;
    logic       brk_d = 1'b0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_q[$];
    int         t_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
            brk_d  <= 1'b0;
        end else begin
            brk_d <= tx_break;
            if (!rx_act) begin
                if (!m_serial && !tx_break && !brk_d) begin
                    rx_act <= 1'b1;
                    rx_cnt <= 1;
                    rx_t0  <= cyc;
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5)
                    rx_sh[(rx_cnt - 15) / 10] <= m_serial;
                if (rx_cnt == 95 && !m_serial) rx_bad <= rx_bad + 1;
                if (rx_cnt == 99) begin
                    rx_act <= 1'b0;
                    rx_q.push_back(rx_sh);
                    t_q.push_back(rx_t0);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ser(input int sel);
        case (sel)
            0:       return m_serial;
            1:       return e_serial;
            default: return o_serial;
        endcase
    endfunction

    function automatic logic bsy(input int sel);
        case (sel)
            0:       return m_busy;
            1:       return e_busy;
            default: return o_busy;
        endcase
    endfunction

    // One bit period (10 clk): line must hold exp on every sample
    task automatic period(input int sel, input logic exp, input string tag);
        logic ok;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ser(sel) !== exp) ok = 1'b0;
            if (bsy(sel)) busy_tally++;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic frame(input int sel, input logic [8:0] d, input int nb,
                         input int par, input int nstop, input string tag);
        period(sel, 1'b0, {tag, " start"});
        for (int i = 0; i < nb; i++) period(sel, d[i], $sformatf("%s d%0d", tag, i));
        if (par >= 0) period(sel, par[0], {tag, " parity"});
        for (int s = 0; s < nstop; s++) period(sel, 1'b1, $sformatf("%s stop%0d", tag, s));
    endtask

    task automatic wait_frames(input int target, input string tag);
        int w;
        w = 0;
        while (rx_q.size() < target && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, rx_q.size(), target);
    endtask

    initial begin
        logic [7:0] c5 [5];
        int base, gap, w, hi;
        logic ok;
        c5[0] = 8'h3A; c5[1] = 8'hC5; c5[2] = 8'h0F; c5[3] = 8'hF0; c5[4] = 8'h81;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst serial", m_serial, 1);
        chk("rst busy", m_busy, 0);
        chk("rst count", m_count, 0);
        chk("rst ready", m_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 8N1 frame, 0xA5
        m_data = 8'hA5; m_valid = 1'b1;
        @(negedge clk); m_valid = 1'b0;
        chk("a5 pop-cycle serial", m_serial, 1);
        chk("a5 pop-cycle count", m_count, 1);
        chk("a5 pop-cycle busy", m_busy, 0);
        busy_tally = 0;
        frame(0, 9'h0A5, 8, -1, 1, "a5");
        chk("a5 busy cycles", busy_tally, 100);
        @(negedge clk);
        chk("a5 idle busy", m_busy, 0);
        chk("a5 idle serial", m_serial, 1);
        chk("a5 idle count", m_count, 0);

        // 7E2 and 7O2 with 0x55: data 1010101, parity 0 (even) / 1 (odd)
        e_data = 7'h55; e_valid = 1'b1;
        @(negedge clk); e_valid = 1'b0;
        chk("even pop-cycle serial", e_serial, 1);
        busy_tally = 0;
        frame(1, 9'h055, 7, 0, 2, "even");
        chk("even busy cycles", busy_tally, 110);
        @(negedge clk);
        chk("even idle busy", e_busy, 0);

        o_data = 7'h55; o_valid = 1'b1;
        @(negedge clk); o_valid = 1'b0;
        chk("odd pop-cycle serial", o_serial, 1);
        busy_tally = 0;
        frame(2, 9'h055, 7, 1, 2, "odd");
        chk("odd busy cycles", busy_tally, 110);
        @(negedge clk);
        chk("odd idle busy", o_busy, 0);

        // Back-to-back: five characters with tx_valid held
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            m_data = c5[i]; m_valid = 1'b1;
            w = 0;
            while (!m_ready && w < 200) begin @(negedge clk); w++; end
            @(negedge clk);
        end
        chk("b2b count full", m_count, 4);
        chk("b2b ready low", m_ready, 0);
        m_data = 8'hEE;
        repeat (3) @(negedge clk);
        chk("b2b full hold count", m_count, 4);
        chk("b2b full hold ready", m_ready, 0);
        m_valid = 1'b0;
        gap = 0;
        w = 0;
        while (rx_q.size() < base + 5 && w < 1000) begin
            @(negedge clk);
            w++;
            if (rx_q.size() < base + 5 && !m_busy) gap++;
        end
        chk("b2b frames", rx_q.size(), base + 5);
        for (int i = 0; i < 5; i++)
            if (base + i < rx_q.size()) chk($sformatf("b2b data%0d", i), rx_q[base+i], c5[i]);
        for (int i = 1; i < 5; i++)
            if (base + i < t_q.size()) chk($sformatf("b2b spacing%0d", i), t_q[base+i] - t_q[base+i-1], 100);
        chk("b2b busy gaps", gap, 0);
        chk("b2b stop bits", rx_bad, 0);
        repeat (2) @(negedge clk);
        chk("b2b drained count", m_count, 0);
        chk("b2b drained busy", m_busy, 0);

        // Push and pop on the same edge at fifo_count = 2
        base = rx_q.size();
        m_data = 8'h69; m_valid = 1'b1;
        @(negedge clk); m_data = 8'h96;
        @(negedge clk); m_data = 8'hD2;
        @(negedge clk); m_valid = 1'b0;
        chk("pp count before", m_count, 2);
        repeat (98) @(negedge clk);
        m_data = 8'h2D; m_valid = 1'b1;
        chk("pp count at edge", m_count, 2);
        @(negedge clk); m_valid = 1'b0;
        chk("pp count after", m_count, 2);
        chk("pp busy", m_busy, 1);
        wait_frames(base + 4, "pp frames");
        if (base + 3 < rx_q.size()) begin
            chk("pp data0", rx_q[base], 8'h69);
            chk("pp data1", rx_q[base+1], 8'h96);
            chk("pp data2", rx_q[base+2], 8'hD2);
            chk("pp data3", rx_q[base+3], 8'h2D);
        end
        repeat (3) @(negedge clk);

        // Asynchronous reset during data bit 3 of 0xA5 (bit value 0)
        m_data = 8'hA5; m_valid = 1'b1;
        @(negedge clk); m_data = 8'h3C;
        @(negedge clk); m_valid = 1'b0;
        repeat (44) @(negedge clk);
        chk("mid bit3 serial", m_serial, 0);
        chk("mid count", m_count, 1);
        rst_n = 1'b0;
        #1;
        chk("async rst serial", m_serial, 1);
        chk("async rst count", m_count, 0);
        chk("async rst busy", m_busy, 0);
        chk("async rst ready", m_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (m_serial !== 1'b1 || m_busy !== 1'b0) ok = 1'b0;
        end
        chk("post rst quiet", {31'd0, ok}, 32'd1);
        base = rx_q.size();
        m_data = 8'h5A; m_valid = 1'b1;
        @(negedge clk); m_valid = 1'b0;
        wait_frames(base + 1, "post rst frame");
        if (base < rx_q.size()) chk("post rst data", rx_q[base], 8'h5A);
        repeat (3) @(negedge clk);

`ifdef UART_TX_BREAK_EN
        // Break raised mid-frame with one character queued
        base = rx_q.size();
        m_data = 8'hC3; m_valid = 1'b1;
        @(negedge clk); m_data = 8'h7E;
        @(negedge clk); m_valid = 1'b0;
        repeat (30) @(negedge clk);
        tx_break = 1'b1;
        repeat (75) @(negedge clk);
        chk("brk line low", m_serial, 0);
        chk("brk no pop", m_count, 1);
        chk("brk busy", m_busy, 0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (m_serial !== 1'b0 || m_count !== 3'd1) ok = 1'b0;
        end
        chk("brk held", {31'd0, ok}, 32'd1);
        tx_break = 1'b0;
        hi = 0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            if (m_serial) hi++;
        end while ((hi == 0 || m_serial) && w < 100);
        chk("brk recovery high", {31'd0, (hi >= 10)}, 32'd1);
        wait_frames(base + 2, "brk frames");
        if (base + 1 < rx_q.size()) begin
            chk("brk data0", rx_q[base], 8'hC3);
            chk("brk data1", rx_q[base+1], 8'h7E);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
